crc_engine: RTL and testbench

Parametrised bit-serial CRC engine for the SD/SPI side of the cart: generalises the fixed CRC7 accumulator into a configurable-width, configurable-polynomial, multi-lane engine. Accumulates a CRC over a counted run of data bits on one or more lanes (1 lane for SPI/CMD, 4 lanes for SD 4-bit data), then either shifts the CRC out behind the data (generate mode) or compares it against received CRC bits (check mode). Sits between the SPI/SD shifter and the command/data sequencers, clocked by the SPI bit clock.

---
 rtl/crc_pkg.sv | 15 +
 rtl/crc_lane.sv | 60 ++++++
 rtl/crc_engine.sv | 132 +++++++++++++
 tb/tb_crc_engine.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/crc_pkg.sv
// Shared definitions for the bit-serial CRC engine: FSM encoding and
// the standard SD polynomials.
package crc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_SEND  = 2'd2,
        ST_CHECK = 2'd3
    } crc_state_e;

    localparam logic [6:0]  CRC7_SD_POLY     = 7'h09;
    localparam logic [15:0] CRC16_CCITT_POLY = 16'h1021;

endpackage

// File: rtl/crc_lane.sv
// One CRC lane: LFSR that accumulates data bits, then shifts its contents
// out MSB first (generate) or compares them against received bits (check)
// with a sticky error flag.
module crc_lane
    import crc_pkg::*;
#(
    parameter int               CRC_W = 16,
    parameter logic [CRC_W-1:0] POLY  = CRC_W'(CRC16_CCITT_POLY)
) (
    input  logic             spi_clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             acc_en,
    input  logic             shift_en,
    input  logic             chk_en,
    input  logic             din,
    output logic             msb,
    output logic [CRC_W-1:0] crc_nxt,
    output logic             err_nxt
);

    logic [CRC_W-1:0] crc_q, crc_d;
    logic             err_q, err_d;
    logic             fb;

    assign msb     = crc_q[CRC_W-1];
    assign crc_nxt = crc_d;
    assign err_nxt = err_d;

    // Next LFSR value: clear, accumulate with feedback, or plain shift-out;
    // in check mode the outgoing MSB is compared with the incoming bit.
    always_comb begin
        crc_d = crc_q;
        err_d = err_q;
        fb    = din ^ crc_q[CRC_W-1];
        if (clr) begin
            crc_d = '0;
            err_d = 1'b0;
        end else if (acc_en) begin
            crc_d = {crc_q[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
        end else if (shift_en) begin
            crc_d = {crc_q[CRC_W-2:0], 1'b0};
            if (chk_en) begin
                err_d = err_q | fb;
            end
        end
    end

    // Lane state registers.
    always_ff @(posedge spi_clk or negedge reset) begin
        if (!reset) begin
            crc_q <= '0;
            err_q <= 1'b0;
        end else begin
            crc_q <= crc_d;
            err_q <= err_d;
        end
    end

endmodule

// File: rtl/crc_engine.sv
// Multi-lane bit-serial CRC engine: counts a run of data bits through the
// lane LFSRs, then either streams the CRC out or checks received CRC bits.
module crc_engine
    import crc_pkg::*;
#(
    parameter int               CRC_W = 16,
    parameter logic [CRC_W-1:0] POLY  = CRC_W'(CRC16_CCITT_POLY),
    parameter int               LANES = 1,
    parameter int               LEN_W = 13
) (
    input  logic                   spi_clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   mode,
    input  logic [LEN_W-1:0]       len,
    input  logic                   bit_en,
    input  logic [LANES-1:0]       din,
    output logic [LANES-1:0]       dout,
    output logic                   dout_valid,
    output logic                   busy,
    output logic                   done,
    output logic                   crc_err,
    output logic [LANES*CRC_W-1:0] crc_out
);

    crc_state_e             state_q, state_d;
    logic [LEN_W-1:0]       cnt_q, cnt_d;
    logic                   mode_q, mode_d;
    logic [LANES*CRC_W-1:0] crc_out_q, crc_out_d;
    logic                   crc_err_q, crc_err_d;
    logic                   done_q, done_d;

    logic                          clr, acc_en, shift_en, chk_en;
    logic [LANES-1:0]              lane_msb;
    logic [LANES-1:0]              lane_err;
    logic [LANES-1:0][CRC_W-1:0]   lane_nxt;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        crc_lane #(.CRC_W(CRC_W), .POLY(POLY)) u_lane (
            .spi_clk  (spi_clk),
            .reset    (reset),
            .clr      (clr),
            .acc_en   (acc_en),
            .shift_en (shift_en),
            .chk_en   (chk_en),
            .din      (din[l]),
            .msb      (lane_msb[l]),
            .crc_nxt  (lane_nxt[l]),
            .err_nxt  (lane_err[l])
        );
    end

    assign busy       = (state_q != ST_IDLE);
    assign dout       = (state_q == ST_SEND) ? lane_msb : '0;
    assign dout_valid = (state_q == ST_SEND) & bit_en;
    assign done       = done_q;
    assign crc_err    = crc_err_q;
    assign crc_out    = crc_out_q;

    // Run sequencing: start always wins (restart/abort); otherwise each
    // enabled slot advances the counter and the phase ends when it hits 1.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        crc_out_d = crc_out_q;
        crc_err_d = crc_err_q;
        done_d    = 1'b0;
        clr       = 1'b0;
        acc_en    = 1'b0;
        shift_en  = 1'b0;
        chk_en    = 1'b0;
        if (start) begin
            clr       = 1'b1;
            mode_d    = mode;
            crc_out_d = '0;
            crc_err_d = 1'b0;
            if (len == '0) begin
                cnt_d   = LEN_W'(CRC_W);
                state_d = mode ? ST_CHECK : ST_SEND;
            end else begin
                cnt_d   = len;
                state_d = ST_DATA;
            end
        end else if (bit_en) begin
            case (state_q)
                ST_DATA: begin
                    acc_en = 1'b1;
                    cnt_d  = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        crc_out_d = lane_nxt;
                        cnt_d     = LEN_W'(CRC_W);
                        state_d   = mode_q ? ST_CHECK : ST_SEND;
                    end
                end
                ST_SEND, ST_CHECK: begin
                    shift_en = 1'b1;
                    chk_en   = (state_q == ST_CHECK);
                    cnt_d    = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        if (state_q == ST_CHECK) begin
                            crc_err_d = |lane_err;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Control and result registers.
    always_ff @(posedge spi_clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            mode_q    <= 1'b0;
            crc_out_q <= '0;
            crc_err_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            crc_out_q <= crc_out_d;
            crc_err_q <= crc_err_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_crc_engine.sv
// Bench for crc_engine: a 16-bit 4-lane instance and a CRC7 single-lane
// instance, random and fixed runs scored against a polynomial-division model.
module tb_crc_engine;

    typedef struct {
        logic [63:0] crc;
        logic        err;
        logic        mode;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    exp_t        q[2][$];
    logic [31:0] st[2][4];
    int          nv[2];

    logic        st16 = 0, md16 = 0, en16 = 0;
    logic [12:0] ln16 = '0;
    logic [3:0]  din16 = '0, dout16;
    logic        dv16, busy16, done16, err16;
    logic [63:0] co16;

    logic        st7 = 0, md7 = 0, en7 = 0;
    logic [12:0] ln7 = '0;
    logic        din7 = 0, dout7, dv7, busy7, done7, err7;
    logic [6:0]  co7;

    crc_engine #(.CRC_W(16), .POLY(16'h1021), .LANES(4), .LEN_W(13)) u16 (
        .spi_clk(clk), .reset(rst_n), .start(st16), .mode(md16), .len(ln16),
        .bit_en(en16), .din(din16), .dout(dout16), .dout_valid(dv16),
        .busy(busy16), .done(done16), .crc_err(err16), .crc_out(co16)
    );

    crc_engine #(.CRC_W(7), .POLY(7'h09), .LANES(1), .LEN_W(13)) u7 (
        .spi_clk(clk), .reset(rst_n), .start(st7), .mode(md7), .len(ln7),
        .bit_en(en7), .din(din7), .dout(dout7), .dout_valid(dv7),
        .busy(busy7), .done(done7), .crc_err(err7), .crc_out(co7)
    );

    initial forever #5 clk = ~clk;
    initial forever @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h (t=%0t)", name, got, want, $time);
        end
    endtask

    // CRC as the remainder of M(x)*x^W divided by G(x), by long division.
    function automatic logic [31:0] ref_crc(input bit m[$], input int w, input logic [31:0] poly);
        logic [32:0] r = '0;
        logic [32:0] g = (33'd1 << w) | {1'b0, poly};
        for (int i = 0; i < m.size() + w; i++) begin
            r = (r << 1) | ((i < m.size()) ? 33'(m[i]) : 33'd0);
            if (r[w]) r = r ^ g;
        end
        return r[31:0];
    endfunction

    task automatic drive(input int sel, input logic s, input logic m, input int ln,
                         input logic e, input logic [3:0] d);
        if (sel == 1) begin
            st7 = s; md7 = m; ln7 = 13'(ln); en7 = e; din7 = d[0];
        end else begin
            st16 = s; md16 = m; ln16 = 13'(ln); en16 = e; din16 = d;
        end
    endtask

    // Monitor step for one instance: gathers the dout stream and scores done.
    task automatic score(input int sel, input logic s, input logic dn, input logic dv,
                         input logic [3:0] dq, input logic [63:0] co, input logic er);
        int          w = (sel == 1) ? 7 : 16;
        int          nl = (sel == 1) ? 1 : 4;
        logic [31:0] mask = (32'd1 << w) - 32'd1;
        exp_t        e;
        if (dn) begin
            if (q[sel].size() == 0) begin
                chk($sformatf("unexp_done%0d", sel), 64'd1, 64'd0);
            end else begin
                e = q[sel].pop_front();
                chk($sformatf("crc_out%0d", sel), co, e.crc);
                chk($sformatf("crc_err%0d", sel), 64'(er), 64'(e.err));
                chk($sformatf("done_cyc%0d", sel), 64'(cyc), 64'(e.cyc));
                if (e.mode == 1'b0) begin
                    chk($sformatf("dout_cnt%0d", sel), 64'(nv[sel]), 64'(w));
                    for (int l = 0; l < nl; l++)
                        chk($sformatf("dout%0d_l%0d", sel, l), 64'(st[sel][l] & mask),
                            64'(32'(e.crc >> (l * w)) & mask));
                end else begin
                    chk($sformatf("dout_cnt%0d", sel), 64'(nv[sel]), 64'd0);
                end
            end
            for (int l = 0; l < 4; l++) st[sel][l] = '0;
            nv[sel] = 0;
        end
        if (s) begin
            for (int l = 0; l < 4; l++) st[sel][l] = '0;
            nv[sel] = 0;
        end else if (dv) begin
            for (int l = 0; l < nl; l++) st[sel][l] = {st[sel][l][30:0], dq[l]};
            nv[sel]++;
        end
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            nv[s] = 0;
            for (int l = 0; l < 4; l++) st[s][l] = '0;
        end
        forever @(negedge clk) begin
            if (!rst_n) begin
                for (int s = 0; s < 2; s++) begin
                    nv[s] = 0;
                    for (int l = 0; l < 4; l++) st[s][l] = '0;
                end
            end else begin
                score(0, st16, done16, dv16, dout16, co16, err16);
                score(1, st7, done7, dv7, {3'b0, dout7}, {57'b0, co7}, err7);
            end
        end
    end

    task automatic rst_chk(input string tag);
        chk({tag, "_busy16"}, 64'(busy16), 64'd0);
        chk({tag, "_done16"}, 64'(done16), 64'd0);
        chk({tag, "_err16"},  64'(err16),  64'd0);
        chk({tag, "_co16"},   co16,        64'd0);
        chk({tag, "_dout16"}, 64'({dv16, dout16}), 64'd0);
        chk({tag, "_busy7"},  64'(busy7),  64'd0);
        chk({tag, "_co7"},    64'(co7),    64'd0);
        chk({tag, "_dout7"},  64'({dv7, dout7, done7, err7}), 64'd0);
    endtask

    // One run: kind 0 random, 1 all ones, 2 CMD0 (0x40 then zeros).
    // known >= 0 overrides the model with a fixed per-lane CRC value.
    // abort_after >= 0 leaves the run after that many slots without a done.
    task automatic run(input int sel, input bit md, input int ln, input int kind, input bit gap,
                       input int bad_lane, input int bad_bit, input longint known,
                       input int abort_after);
        int          w = (sel == 1) ? 7 : 16;
        int          nl = (sel == 1) ? 1 : 4;
        int          slots = ln + w;
        bit          msg[4][$];
        logic [31:0] r[4];
        logic [3:0]  d;
        exp_t        e;
        int          k;
        for (int l = 0; l < nl; l++)
            for (int i = 0; i < ln; i++)
                msg[l].push_back(kind == 1 ? 1'b1 : kind == 2 ? (i == 1) : 1'($urandom_range(0, 1)));
        e.crc = '0;
        for (int l = 0; l < 4; l++) r[l] = '0;
        for (int l = 0; l < nl; l++) begin
            r[l] = (known >= 0) ? known[31:0]
                                : ref_crc(msg[l], w, (sel == 1) ? 32'h09 : 32'h1021);
            for (int b = 0; b < w; b++) e.crc[l * w + b] = r[l][b];
        end
        e.err  = md && (bad_lane >= 0);
        e.mode = md;
        @(posedge clk) #1;
        e.cyc = cyc + 1 + slots * (gap ? 2 : 1);
        drive(sel, 1'b1, md, ln, 1'($urandom_range(0, 1)), 4'($urandom));
        if (abort_after < 0) q[sel].push_back(e);
        for (int i = 0; i < slots; i++) begin
            if (abort_after >= 0 && i == abort_after) return;
            @(posedge clk) #1;
            if (gap) begin
                drive(sel, 1'b0, md, ln, 1'b0, 4'($urandom));
                @(posedge clk) #1;
            end
            d = 4'($urandom);
            for (int l = 0; l < nl; l++) begin
                if (i < ln) d[l] = msg[l][i];
                else if (md) d[l] = r[l][w - 1 - (i - ln)] ^ (l == bad_lane && (i - ln) == bad_bit);
            end
            drive(sel, 1'b0, md, ln, 1'b1, d);
        end
        @(posedge clk) #1;
        drive(sel, 1'b0, md, ln, 1'b0, 4'b0);
        k = 0;
        while (q[sel].size() != 0 && k < 20) begin
            @(posedge clk) #1;
            k++;
        end
        if (q[sel].size() != 0) begin
            chk($sformatf("done_timeout%0d", sel), 64'(q[sel].size()), 64'd0);
            q[sel].delete();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        #12;
        rst_chk("reset");
        @(posedge clk) #1;
        rst_n = 1'b1;

        // CRC7 instance: CMD0, CMD0 with gapped bit_en, len=0, random runs
        run(1, 0, 40, 2, 0, -1, 0, 64'h4A, -1);
        run(1, 0, 40, 2, 1, -1, 0, 64'h4A, -1);
        run(1, 0, 0, 0, 0, -1, 0, 64'h0, -1);
        run(1, 1, 0, 0, 0, 0, 3, 64'h0, -1);
        for (int k = 0; k < 6; k++)
            run(1, k[0], $urandom_range(1, 48), 0, k[1], (k >= 4 && k[0]) ? 0 : -1,
                $urandom_range(0, 6), -1, -1);

        // 16-bit 4-lane instance: 512 bytes of 0xFF, check good/bad, random
        run(0, 0, 4096, 1, 0, -1, 0, 64'h7FA1, -1);
        run(0, 1, 4096, 1, 0, -1, 0, 64'h7FA1, -1);
        run(0, 1, 4096, 1, 0, 0, 5, 64'h7FA1, -1);
        run(0, 1, 1024, 0, 0, 3, $urandom_range(0, 15), -1, -1);
        for (int k = 0; k < 4; k++)
            run(0, k[0], $urandom_range(1, 300), 0, k[1], (k == 3) ? $urandom_range(0, 3) : -1,
                $urandom_range(0, 15), -1, -1);

        // start while busy: aborted run gives no done, restart completes
        run(0, 0, 200, 0, 0, -1, 0, -1, 50);
        run(0, 1, 30, 0, 0, -1, 0, -1, -1);

        // reset mid-DATA, then a clean gapped run
        run(0, 0, 100, 0, 0, -1, 0, -1, 20);
        @(posedge clk) #1;
        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, 0, 1'b0, 4'b0);
        #1;
        rst_chk("midrun");
        @(posedge clk) #1;
        rst_n = 1'b1;
        run(0, 0, 64, 0, 1, -1, 0, -1, -1);
        run(1, 1, 40, 2, 0, -1, 0, 64'h4A, -1);

        repeat (4) @(posedge clk);
        chk("pending16", 64'(q[0].size()), 64'd0);
        chk("pending7", 64'(q[1].size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
